// File: rtl/fft_frame_collector.sv
// Collects one FFT output frame delivered LANES samples per beat, then replays it
// one sample per cycle on a valid/ready stream, optionally in bit-reversed address order.
module fft_frame_collector #(
  parameter int WIDTH     = 9,
  parameter int LANES     = 16,
  parameter int FRAME_LEN = 512,
  parameter int BITREV    = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         din_valid,
  input  logic signed [WIDTH+1:0]      din_re [0:LANES-1],
  input  logic signed [WIDTH+1:0]      din_im [0:LANES-1],
  output logic                         dout_valid,
  input  logic                         dout_ready,
  output logic signed [WIDTH+1:0]      dout_re,
  output logic signed [WIDTH+1:0]      dout_im,
  output logic [$clog2(FRAME_LEN)-1:0] dout_idx,
  output logic                         dout_last,
  output logic                         busy,
  output logic                         overflow
);

  localparam int DW    = WIDTH + 2;
  localparam int AW    = $clog2(FRAME_LEN);
  localparam int BEATS = FRAME_LEN / LANES;
  localparam int BW    = $clog2(BEATS);
  localparam int LW    = $clog2(LANES);

  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_DRAIN} state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [BW-1:0]        r_beat;
  logic [AW-1:0]        r_k;
  logic                 r_vld;
  logic                 r_ovf;
  logic signed [DW-1:0] r_dout_re;
  logic signed [DW-1:0] r_dout_im;
  logic signed [DW-1:0] r_mem_re [0:FRAME_LEN-1];
  logic signed [DW-1:0] r_mem_im [0:FRAME_LEN-1];

  logic                 w_wr_en;
  logic [BW-1:0]        w_wr_beat;
  logic                 w_last_beat;
  logic                 w_hs;
  logic                 w_final;
  logic                 w_load;
  logic [AW-1:0]        w_rd_k;
  logic [AW-1:0]        w_rd_addr;

  function automatic logic [AW-1:0] f_bitrev(input logic [AW-1:0] a);
    logic [AW-1:0] r;
    for (int i = 0; i < AW; i++) r[i] = a[AW-1-i];
    return r;
  endfunction

  always_comb begin
    w_wr_en     = din_valid && (r_state != S_DRAIN);
    w_wr_beat   = (r_state == S_IDLE) ? '0 : r_beat;
    w_last_beat = (r_state == S_CAPTURE) && din_valid && (r_beat == BW'(BEATS - 1));
    w_hs        = r_vld && dout_ready;
    w_final     = w_hs && (r_k == AW'(FRAME_LEN - 1));
    // The next sample is fetched while the current one handshakes, giving 1 sample/cycle.
    w_load      = (r_state == S_DRAIN) && (!r_vld || (w_hs && !w_final));
    w_rd_k      = w_hs ? (r_k + AW'(1)) : r_k;
    w_rd_addr   = (BITREV != 0) ? f_bitrev(w_rd_k) : w_rd_k;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (din_valid)   w_state_nxt = S_CAPTURE;
      S_CAPTURE: if (w_last_beat) w_state_nxt = S_DRAIN;
      S_DRAIN:   if (w_final)     w_state_nxt = S_IDLE;
      default:                    w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_beat    <= '0;
      r_k       <= '0;
      r_vld     <= 1'b0;
      r_ovf     <= 1'b0;
      r_dout_re <= '0;
      r_dout_im <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_wr_en) r_beat <= w_wr_beat + BW'(1);
      if (w_final) begin
        r_k   <= '0;
        r_vld <= 1'b0;
      end else if (w_hs) begin
        r_k <= r_k + AW'(1);
      end
      if (w_load) begin
        r_vld     <= 1'b1;
        r_dout_re <= r_mem_re[w_rd_addr];
        r_dout_im <= r_mem_im[w_rd_addr];
      end
      if (din_valid && (r_state == S_DRAIN)) r_ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      for (int j = 0; j < LANES; j++) begin
        r_mem_re[{w_wr_beat, LW'(j)}] <= din_re[j];
        r_mem_im[{w_wr_beat, LW'(j)}] <= din_im[j];
      end
    end
  end

  assign dout_valid = r_vld;
  assign dout_re    = r_dout_re;
  assign dout_im    = r_dout_im;
  assign dout_idx   = r_k;
  assign dout_last  = r_vld && (r_k == AW'(FRAME_LEN - 1));
  assign busy       = (r_state != S_IDLE);
  assign overflow   = r_ovf;

endmodule

// File: tb/tb_fft_frame_collector.sv
// Directed bench for fft_frame_collector: natural-order and bit-reversed instances share
// stimulus; expected samples are queued per frame and popped on each handshake.
module tb_fft_frame_collector;
  localparam int DW = 11;
  localparam int L  = 16;
  localparam int N  = 512;
  localparam int AW = 9;

  logic clk = 1'b0;
  logic rst, din_valid, dout_ready;
  logic signed [DW-1:0] din_re [0:L-1];
  logic signed [DW-1:0] din_im [0:L-1];

  logic n_valid, n_last, n_busy, n_ovf;
  logic signed [DW-1:0] n_re, n_im;
  logic [AW-1:0] n_idx;
  logic r_valid, r_last, r_busy, r_ovf;
  logic signed [DW-1:0] r_re, r_im;
  logic [AW-1:0] r_idx;

  int vectors = 0;
  int miscompares = 0;
  logic signed [DW-1:0] fre [0:N-1];
  logic signed [DW-1:0] fim [0:N-1];
  logic [31:0] q_nat [$];
  logic [31:0] q_rev [$];

  always #5 clk = ~clk;

  fft_frame_collector #(.WIDTH(9), .LANES(16), .FRAME_LEN(512), .BITREV(0)) u_nat (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din_re(din_re), .din_im(din_im),
    .dout_valid(n_valid), .dout_ready(dout_ready), .dout_re(n_re), .dout_im(n_im),
    .dout_idx(n_idx), .dout_last(n_last), .busy(n_busy), .overflow(n_ovf));

  fft_frame_collector #(.WIDTH(9), .LANES(16), .FRAME_LEN(512), .BITREV(1)) u_rev (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din_re(din_re), .din_im(din_im),
    .dout_valid(r_valid), .dout_ready(dout_ready), .dout_re(r_re), .dout_im(r_im),
    .dout_idx(r_idx), .dout_last(r_last), .busy(r_busy), .overflow(r_ovf));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [AW-1:0] rev9(input logic [AW-1:0] k);
    logic [AW-1:0] r;
    r = {<<{k}};
    return r;
  endfunction

  // mode 0: ramp; mode 1: ramp with extremes at address 0; mode 2: alternate pattern
  task automatic make_frame(input int mode);
    logic [AW-1:0] a;
    for (int i = 0; i < N; i++) begin
      case (mode)
        2:       begin fre[i] = DW'(-i); fim[i] = DW'(i + 500); end
        default: begin fre[i] = DW'(i);  fim[i] = DW'(-i);      end
      endcase
    end
    if (mode == 1) begin
      fre[0] = -11'sd1024;
      fim[0] = 11'sd1023;
    end
    for (int k = 0; k < N; k++) begin
      a = rev9(AW'(k));
      q_nat.push_back({AW'(k), fre[k], fim[k], k == N - 1});
      q_rev.push_back({AW'(k), fre[a], fim[a], k == N - 1});
    end
  endtask

  task automatic send_frame(input int gap);
    for (int b = 0; b < N / L; b++) begin
      for (int j = 0; j < L; j++) begin
        din_re[j] = fre[b*L + j];
        din_im[j] = fim[b*L + j];
      end
      din_valid = 1'b1;
      step();
      din_valid = 1'b0;
      chk("busy_capture", {n_busy, r_busy}, 2'b11);
      if (b < N / L - 1) begin
        for (int g = 0; g < gap; g++) begin
          step();
          chk("busy_gap", {n_busy, r_busy}, 2'b11);
        end
      end
    end
  endtask

  task automatic post_capture();
    dout_ready = 1'b1;
    chk("lat_edge1", {n_valid, r_valid, n_busy, r_busy}, 4'b0011);
    step();
    chk("lat_edge2", {n_valid, r_valid}, 2'b11);
  endtask

  task automatic drain(input int toggle, input int stop_k, input int ovf_at, input int spot,
                       output int vcycles);
    int n;
    n = 0;
    vcycles = 0;
    while (n < N && n != stop_k && vcycles < 4000) begin
      dout_ready = (toggle != 0) ? (vcycles % 2 == 1) : 1'b1;
      din_valid  = (ovf_at >= 0) && (vcycles == ovf_at || vcycles == ovf_at + 1);
      if (ovf_at >= 0 && vcycles == ovf_at + 1) chk("ovf_set", {n_ovf, r_ovf}, 2'b11);
      chk("drain_valid", {n_valid, r_valid}, 2'b11);
      if (n_valid && r_valid) begin
        chk("nat_sample", {n_idx, n_re, n_im, n_last}, q_nat[0]);
        chk("rev_sample", {r_idx, r_re, r_im, r_last}, q_rev[0]);
        if (spot != 0 && dout_ready) begin
          case (r_idx)
            9'd1:   chk("rev_k1",   r_re, 64'(11'sd256));
            9'd2:   chk("rev_k2",   r_re, 64'(11'sd128));
            9'd3:   chk("rev_k3",   r_re, 64'(11'sd384));
            9'd511: chk("rev_k511", r_re, 64'(11'sd511));
            default: ;
          endcase
        end
        if (dout_ready) begin
          void'(q_nat.pop_front());
          void'(q_rev.pop_front());
          n++;
        end
      end
      step();
      vcycles++;
    end
    din_valid = 1'b0;
    if (stop_k < 0) begin
      chk("drain_count", n, N);
      chk("end_idle", {n_valid, r_valid, n_busy, r_busy, n_idx, r_idx}, 64'd0);
    end else begin
      chk("drain_stop", n, stop_k);
    end
  endtask

  initial begin
    int vc;
    rst = 1'b1;
    din_valid = 1'b0;
    dout_ready = 1'b0;
    for (int j = 0; j < L; j++) begin
      din_re[j] = '0;
      din_im[j] = '0;
    end
    step(); step(); step();
    rst = 1'b0;
    chk("reset_nat", {n_valid, n_re, n_im, n_idx, n_last, n_busy, n_ovf}, 64'd0);
    chk("reset_rev", {r_valid, r_re, r_im, r_idx, r_last, r_busy, r_ovf}, 64'd0);

    // back-to-back ramp with extremes, ready held high
    make_frame(1);
    send_frame(0);
    post_capture();
    drain(0, -1, -1, 0, vc);
    chk("s1_cycles", vc, N);

    // gapped ramp, spot-check bit-reversed values
    make_frame(0);
    send_frame(3);
    post_capture();
    drain(0, -1, -1, 1, vc);

    // backpressure: ready alternates 0,1 while valid
    make_frame(2);
    send_frame(0);
    post_capture();
    drain(1, -1, -1, 0, vc);
    chk("bp_cycles", vc, 2 * N);
    chk("ovf_clear", {n_ovf, r_ovf}, 2'b00);

    // two beats dropped during drain, then another frame
    make_frame(0);
    send_frame(0);
    post_capture();
    drain(0, -1, 5, 0, vc);
    chk("ovf_sticky", {n_ovf, r_ovf}, 2'b11);
    make_frame(2);
    send_frame(1);
    post_capture();
    drain(0, -1, -1, 0, vc);
    chk("ovf_sticky2", {n_ovf, r_ovf}, 2'b11);

    // reset while sample 100 is being handshaked
    make_frame(0);
    send_frame(0);
    post_capture();
    drain(0, 100, -1, 0, vc);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_mid", {n_valid, n_busy, n_ovf, n_idx, r_valid, r_busy, r_ovf, r_idx}, 64'd0);
    q_nat.delete();
    q_rev.delete();
    make_frame(0);
    send_frame(0);
    post_capture();
    drain(0, -1, -1, 1, vc);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
